// File: rtl/bmd_latency_pkg.sv
// Shared constants and types for the multi-channel latency stamp buffer.
// Mode encodings select how the TX drain request is raised.
package bmd_latency_pkg;

   localparam int TS_WIDTH_DEF = 38;
   localparam int MODE_FULL    = 0;
   localparam int MODE_THRESH  = 1;
   localparam int DROP_CNT_W   = 16;

   typedef enum logic [0:0] {
      TRIG_IDLE  = 1'b0,
      TRIG_DRAIN = 1'b1
   } trig_state_e;

endpackage

// File: rtl/bmd_stamp_fifo.sv
// Generic synchronous FIFO with a registered (1-cycle) read port and an up/down occupancy counter.
// Callers must qualify push/pop; level_next exposes the post-operation occupancy.
module bmd_stamp_fifo
   import bmd_latency_pkg::*;
#(
   parameter int WIDTH = 42,
   parameter int DEPTH = 8192
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     level,
   output logic [$clog2(DEPTH):0]     level_next,
   output logic                       full,
   output logic                       empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             rd_valid_q, rd_valid_d;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rd_valid_d = pop;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase
      full_d  = (level_d == DEPTH_L);
      empty_d = (level_d == {CNT_W{1'b0}});
   end

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Read-first output register: a same-address push and pop returns the old entry.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         rd_data_q <= {WIDTH{1'b0}};
      end else if (pop) begin
         rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         level_q    <= {CNT_W{1'b0}};
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign level      = level_q;
   assign level_next = level_d;
   assign full       = full_q;
   assign empty      = empty_q;

endmodule

// File: rtl/bmd_latency_stamp_buffer.sv
// Multi-channel SOP timestamp capture buffer: one {hit mask, timestamp} entry per SOP cycle,
// drained by TX once the trigger condition (full or level threshold) is reached.
module bmd_latency_stamp_buffer
   import bmd_latency_pkg::*;
#(
   parameter int TS_WIDTH = TS_WIDTH_DEF,
   parameter int NUM_CH   = 4,
   parameter int DEPTH    = 8192,
   parameter int MODE     = MODE_FULL
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic [NUM_CH-1:0]         sop,
   input  logic [TS_WIDTH-1:0]       timestamp,
   input  logic [$clog2(DEPTH):0]    thresh,
   input  logic                      rd_en,
   output logic [TS_WIDTH-1:0]       rd_ts,
   output logic [NUM_CH-1:0]         rd_mask,
   output logic                      rd_valid,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      full,
   output logic                      empty,
   output logic                      read_trigger,
   output logic                      overflow,
   output logic [DROP_CNT_W-1:0]     drop_cnt,
   output logic                      underflow
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int WIDTH = NUM_CH + TS_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

   logic [WIDTH-1:0]      rd_data_s;
   logic [CNT_W-1:0]      level_s, level_next_s, eff_thresh_s;
   logic                  full_s, empty_s;
   logic                  wr_s, push_s, pop_s, drop_s, set_s, clear_s;
   trig_state_e           state_q, state_d;
   logic                  read_trigger_q, read_trigger_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // A pop frees a slot in the same cycle, so a push while full is accepted when paired with a pop.
   always_comb begin
      wr_s   = |sop;
      pop_s  = rd_en && !empty_s;
      push_s = wr_s && (!full_s || pop_s);
      drop_s = wr_s && full_s && !pop_s;
   end

   bmd_stamp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .push       (push_s),
      .pop        (pop_s),
      .wr_data    ({sop, timestamp}),
      .rd_data    (rd_data_s),
      .rd_valid   (rd_valid),
      .level      (level_s),
      .level_next (level_next_s),
      .full       (full_s),
      .empty      (empty_s)
   );

   // Trigger looks at post-operation occupancy; a zero threshold behaves as one.
   always_comb begin
      if (thresh == {CNT_W{1'b0}}) begin
         eff_thresh_s = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         eff_thresh_s = thresh;
      end
      if (MODE == MODE_FULL) begin
         set_s = (level_next_s == DEPTH_L);
      end else begin
         set_s = (level_next_s >= eff_thresh_s) || (level_next_s == DEPTH_L);
      end
      clear_s = (level_next_s == {CNT_W{1'b0}});
      case (state_q)
         TRIG_IDLE: begin
            if (set_s) begin
               state_d = TRIG_DRAIN;
            end else begin
               state_d = TRIG_IDLE;
            end
         end
         TRIG_DRAIN: begin
            if (set_s) begin
               state_d = TRIG_DRAIN;
            end else if (clear_s) begin
               state_d = TRIG_IDLE;
            end else begin
               state_d = TRIG_DRAIN;
            end
         end
         default: state_d = TRIG_IDLE;
      endcase
      read_trigger_d = (state_d == TRIG_DRAIN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         state_q        <= TRIG_IDLE;
         read_trigger_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         read_trigger_q <= read_trigger_d;
      end
   end

   always_comb begin
      overflow_d  = overflow_q || drop_s;
      underflow_d = underflow_q || (rd_en && empty_s);
      if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         drop_cnt_q  <= {DROP_CNT_W{1'b0}};
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign rd_ts        = rd_data_s[TS_WIDTH-1:0];
   assign rd_mask      = rd_data_s[TS_WIDTH +: NUM_CH];
   assign level        = level_s;
   assign full         = full_s;
   assign empty        = empty_s;
   assign read_trigger = read_trigger_q;
   assign overflow     = overflow_q;
   assign drop_cnt     = drop_cnt_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_bmd_latency_stamp_buffer.sv
// Directed scoreboard bench: a MODE 0 and a MODE 1 instance share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_bmd_latency_stamp_buffer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  sop = 4'h0;
   logic [37:0] timestamp = 38'd0;
   logic [4:0]  thresh = 5'd5;
   logic        rd_en = 1'b0;

   logic [37:0] rd_ts0, rd_ts1;
   logic [3:0]  rd_mask0, rd_mask1;
   logic        rd_valid0, rd_valid1, full0, full1, empty0, empty1;
   logic        trig0, trig1, ovf0, ovf1, unf0, unf1;
   logic [4:0]  level0, level1;
   logic [15:0] drop0, drop1;

   int n_cmp = 0;
   int n_err = 0;

   logic [41:0] mq[$];
   logic [41:0] eq[$];
   int          mlevel = 0;
   logic        m_ovf = 1'b0, m_unf = 1'b0, m_trig0 = 1'b0, m_trig1 = 1'b0, exp_valid = 1'b0;
   logic [15:0] m_drop = 16'd0;
   logic [37:0] hold_ts = 38'd0;
   logic [3:0]  hold_mask = 4'd0;

   always #5 clk = ~clk;

   bmd_latency_stamp_buffer #(.TS_WIDTH(38), .NUM_CH(4), .DEPTH(DEPTH), .MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .sop(sop), .timestamp(timestamp), .thresh(thresh),
      .rd_en(rd_en), .rd_ts(rd_ts0), .rd_mask(rd_mask0), .rd_valid(rd_valid0), .level(level0),
      .full(full0), .empty(empty0), .read_trigger(trig0), .overflow(ovf0), .drop_cnt(drop0),
      .underflow(unf0));

   bmd_latency_stamp_buffer #(.TS_WIDTH(38), .NUM_CH(4), .DEPTH(DEPTH), .MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .sop(sop), .timestamp(timestamp), .thresh(thresh),
      .rd_en(rd_en), .rd_ts(rd_ts1), .rd_mask(rd_mask1), .rd_valid(rd_valid1), .level(level1),
      .full(full1), .empty(empty1), .read_trigger(trig1), .overflow(ovf1), .drop_cnt(drop1),
      .underflow(unf1));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the reference model, then compare both instances after the edge.
   task automatic cycle(input logic rn, input logic c, input logic [3:0] s, input logic [37:0] t,
                        input logic r);
      logic        pop, push, wr;
      logic [41:0] e;
      int          eff;
      rst_n = rn; clr = c; sop = s; timestamp = t; rd_en = r;
      if (!rn || c) begin
         mq.delete(); eq.delete();
         mlevel = 0; m_ovf = 1'b0; m_unf = 1'b0; m_drop = 16'd0;
         m_trig0 = 1'b0; m_trig1 = 1'b0; exp_valid = 1'b0;
         hold_ts = 38'd0; hold_mask = 4'd0;
      end else begin
         wr   = |s;
         pop  = r && (mlevel != 0);
         push = wr && ((mlevel != DEPTH) || pop);
         if (r && (mlevel == 0)) m_unf = 1'b1;
         if (wr && !push) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
         end
         if (pop) eq.push_back(mq.pop_front());
         if (push) mq.push_back({s, t});
         mlevel = mq.size();
         if (mlevel == DEPTH) m_trig0 = 1'b1;
         else if (mlevel == 0) m_trig0 = 1'b0;
         eff = (thresh == 5'd0) ? 1 : int'(thresh);
         if ((mlevel >= eff) || (mlevel == DEPTH)) m_trig1 = 1'b1;
         else if (mlevel == 0) m_trig1 = 1'b0;
         exp_valid = pop;
      end
      @(posedge clk);
      #1;
      if (exp_valid && (eq.size() > 0)) begin
         e = eq.pop_front();
         hold_ts = e[37:0];
         hold_mask = e[41:38];
      end
      check("rd_valid0", 64'(rd_valid0), 64'(exp_valid));
      check("rd_valid1", 64'(rd_valid1), 64'(exp_valid));
      check("rd_ts0", 64'(rd_ts0), 64'(hold_ts));
      check("rd_ts1", 64'(rd_ts1), 64'(hold_ts));
      check("rd_mask0", 64'(rd_mask0), 64'(hold_mask));
      check("rd_mask1", 64'(rd_mask1), 64'(hold_mask));
      check("level0", 64'(level0), 64'(mlevel));
      check("level1", 64'(level1), 64'(mlevel));
      check("full0", 64'(full0), 64'(mlevel == DEPTH));
      check("empty0", 64'(empty0), 64'(mlevel == 0));
      check("empty1", 64'(empty1), 64'(mlevel == 0));
      check("trigger_mode0", 64'(trig0), 64'(m_trig0));
      check("trigger_mode1", 64'(trig1), 64'(m_trig1));
      check("overflow0", 64'(ovf0), 64'(m_ovf));
      check("overflow1", 64'(ovf1), 64'(m_ovf));
      check("underflow0", 64'(unf0), 64'(m_unf));
      check("drop_cnt0", 64'(drop0), 64'(m_drop));
      check("drop_cnt1", 64'(drop1), 64'(m_drop));
   endtask

   initial begin
      // Reset held with all SOPs active: nothing may be captured.
      cycle(1'b0, 1'b0, 4'hF, 38'd1, 1'b0);
      cycle(1'b0, 1'b0, 4'hF, 38'd2, 1'b0);

      // Fill to full and drain in order; MODE 1 instance triggers at 5.
      thresh = 5'd5;
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h1, 38'(100 + i), 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);

      // Simultaneous SOPs share one entry.
      cycle(1'b1, 1'b0, 4'b1010, 38'd7, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);

      // Overflow: three drops, then push+pop while full, then drain.
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h2, 38'(200 + i), 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h4, 38'(300 + i), 1'b0);
      cycle(1'b1, 1'b0, 4'h8, 38'd400, 1'b1);
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);

      // Threshold 5: partial drain keeps the trigger, empty clears it.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h3, 38'(500 + i), 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);

      // Threshold 0 acts as 1.
      thresh = 5'd0;
      cycle(1'b1, 1'b0, 4'h5, 38'd550, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);

      // Threshold above depth: trigger only on full.
      thresh = 5'd20;
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h6, 38'(700 + i), 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);

      // Set overflow, clr mid-drain at level 8, then pop on empty.
      thresh = 5'd5;
      for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 4'h1, 38'(800 + i), 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b1, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 38'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
